mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single-port memory between instruction fetch (IF) and data access (load/store from EX/MEM). Only one transaction is in flight at a time. Data access has priority over fetch, and a starvation counter guarantees that fetch still makes progress. While any requester is waiting, the block raises a hold request to the hold controller so the pipeline freezes until the access completes.

## Interface
- `STARVE_MAX`, default 3: number of consecutive data grants, with fetch waiting, after which fetch is forced.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  reset; asynchronous, active-low.
- `i_if_req`  in  1  fetch request; held high until `o_if_valid`.
- `i_if_addr`  in  32  fetch address.
- `o_if_rdata`  out  32  fetched instruction; valid when `o_if_valid`=1.
- `o_if_valid`  out  1  one-cycle completion pulse for fetch.
- `i_d_req`  in  1  data request; held high until `o_d_valid`.
- `i_d_we`  in  1  1 = store, 0 = load.
- `i_d_addr`  in  32  data address.
- `i_d_wdata`  in  32  store data.
- `i_d_wmask`  in  4  store byte enables.
- `o_d_rdata`  out  32  load data; valid when `o_d_valid`=1.
- `o_d_valid`  out  1  one-cycle completion pulse for data.
- `o_mem_req`  out  1  memory request; held until `i_mem_ack`.
- `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`  out  1/32/32/4  latched copy of the granted request.
- `i_mem_ack`  in  1  memory completion; `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata`  in  32  memory read data.
- `o_hold_req`  out  1  to hold control; asks for a pipeline freeze.

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY_IF: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- Grant decision, made in IDLE and sampled at the clock edge:
  - Only `i_d_req` high: grant data.
  - Only `i_if_req` high: grant fetch.
  - Both high: grant data, unless `starve_cnt` == `STARVE_MAX`, in which case grant fetch.
  - Neither high: stay in IDLE.
- On grant:
  - Latch we/addr/wdata/wmask into the `o_mem_*` registers. For fetch, latch we=0 and wmask=0.
  - Move to BUSY_IF or BUSY_D.
- In BUSY_*:
  - `o_mem_req`=1 and the latched `o_mem_*` fields are held stable.
  - Input request ports are ignored.
- On `i_mem_ack` in BUSY_*:
  - Register `i_mem_rdata` into the owner's rdata register.
  - Pulse the owner's valid on the next cycle.
  - Return to IDLE.
  - Stores also pulse `o_d_valid`; `o_d_rdata` is then don't-care.
- `starve_cnt`:
  - Width is ceil(log2(`STARVE_MAX`+1)).
  - Increments on each data grant made while `i_if_req`=1, saturating at `STARVE_MAX`.
  - Clears on any fetch grant.
  - Holds on a data grant made while `i_if_req`=0.
- `o_hold_req` is combinational: (`i_d_req` & ~`o_d_valid`) | (`i_if_req` & ~`o_if_valid`).
- Boundary conditions:
  - `i_mem_ack` while in IDLE is ignored; no valid pulse, no state change.
  - A requester that drops its req mid-transaction does not abort it. The transaction completes and the valid still pulses; the requester must ignore it.
  - rdata registers hold their last value between completions.
- Reset asserted at any time, including mid-transaction:
  - state = IDLE.
  - `starve_cnt` = 0.
  - `o_mem_req`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`, `o_if_rdata`, `o_d_rdata`, `o_if_valid`, `o_d_valid` all = 0.
  - The in-flight transaction is abandoned, and an ack that arrives after reset is released is ignored.

## Timing
- Cycle N (IDLE, req sampled): grant registered.
- Cycle N+1: `o_mem_req`=1 with the latched fields.
- First cycle with `i_mem_ack`=1 (cycle A ≥ N+1): rdata captured.
- Cycle A+1:
  - Owner valid = 1 for exactly one cycle.
  - State is IDLE, and a new grant may be sampled at the end of this same cycle.
- Minimum request-to-valid latency is 2 cycles (ack in N+1). Back-to-back transactions are separated by one idle cycle, the A+1 cycle.
- `o_hold_req` reacts combinationally in the same cycle as the request and valid inputs. It is low in the valid cycle if no other requester is waiting.

## Test plan
- **Fetch alone.** `i_if_req`=1, addr=0x100; memory acks in N+1 with 0x00500093. Expect:
  - `o_mem_addr`=0x100, `o_mem_we`=0 in N+1.
  - `o_if_valid`=1 with rdata 0x00500093 in N+2.
  - `o_hold_req`=1 during N..N+1 and 0 in N+2.
- **Store with wait states.** `i_d_req`=1, we=1, addr=0x2000, wdata=0xDEADBEEF, wmask=0xF; ack delayed 3 cycles. Expect:
  - `o_mem_*` fields held stable for 3 cycles.
  - One `o_d_valid` pulse; no `o_if_valid`.
- **Simultaneous requests.** Both requests held continuously, `STARVE_MAX`=3, ack in 1 cycle. Expect the grant order D, D, D, IF, D, D, D, IF.
- **Spurious ack.** `i_mem_ack`=1 while in IDLE with no requests. Expect no valid pulses, `o_mem_req` stays 0, and state remains IDLE.
- **Reset mid-transaction.** Assert `i_reset`=0 while in BUSY_D; release it, then ack. Expect all outputs 0, no `o_d_valid`, `starve_cnt`=0, and a fresh fetch request granted normally afterwards.
- **Request withdrawn.** `i_if_req` drops after the grant. Expect the transaction to complete, `o_if_valid` to pulse once, and `o_hold_req`=0 once no req is high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_wmask,
  output logic [31:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_hold_req
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          grant_d, grant_if, done;

  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wmask_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          if_valid_q;
  logic          d_valid_q;

  // Grant decision in IDLE (data first unless fetch has starved), completion in BUSY.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    grant_d      = 1'b0;
    grant_if     = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_d_req && !(i_if_req && (starve_cnt_q == STARVE_LIM))) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
          // Only a data grant that makes fetch wait counts toward starvation.
          if (i_if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (i_if_req) begin
          grant_if     = 1'b1;
          state_d      = BUSY_IF;
          starve_cnt_d = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (i_mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and starvation counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Latch the granted request, capture read data on ack, and pulse the owner's valid.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_we_q    <= i_d_we;
        mem_addr_q  <= i_d_addr;
        mem_wdata_q <= i_d_wdata;
        mem_wmask_q <= i_d_wmask;
      end else if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_if_addr;
        mem_wdata_q <= '0;
        mem_wmask_q <= '0;
      end
      if (done && (state_q == BUSY_IF)) begin
        if_rdata_q <= i_mem_rdata;
      end
      if (done && (state_q == BUSY_D)) begin
        d_rdata_q <= i_mem_rdata;
      end
      if_valid_q <= done && (state_q == BUSY_IF);
      d_valid_q  <= done && (state_q == BUSY_D);
    end
  end

  assign o_mem_req   = (state_q != IDLE);
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wmask = mem_wmask_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_if_valid  = if_valid_q;
  assign o_d_valid   = d_valid_q;

  // Freeze the pipeline while any requester still waits for its completion.
  assign o_hold_req = (i_d_req & ~d_valid_q) | (i_if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_wmask;
  logic [31:0] o_d_rdata;
  logic        o_d_valid;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_hold_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.STARVE_MAX(3)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_valid  (o_if_valid),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .i_d_wmask   (i_d_wmask),
    .o_d_rdata   (o_d_rdata),
    .o_d_valid   (o_d_valid),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wmask (o_mem_wmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_hold_req  (o_hold_req)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  logic [31:0] grant_exp [8];
  int k;

  initial begin
    grant_exp = '{32'h800, 32'h800, 32'h800, 32'h400, 32'h800, 32'h800, 32'h800, 32'h400};
    i_reset = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_d_req = 1'b0; i_d_we = 1'b0;
    i_d_addr = '0; i_d_wdata = '0; i_d_wmask = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;

    // reset state
    step();
    check_eq("rst_mem_req", o_mem_req, 0);
    check_eq("rst_mem_addr", o_mem_addr, 0);
    check_eq("rst_if_valid", o_if_valid, 0);
    check_eq("rst_d_valid", o_d_valid, 0);
    check_eq("rst_hold", o_hold_req, 0);
    i_reset = 1'b1;
    step();

    // fetch alone, ack in N+1
    i_if_req = 1'b1; i_if_addr = 32'h100;
    #1 check_eq("f_hold_n", o_hold_req, 1);
    step();
    check_eq("f_mem_req", o_mem_req, 1);
    check_eq("f_mem_addr", o_mem_addr, 32'h100);
    check_eq("f_mem_we", o_mem_we, 0);
    check_eq("f_hold_n1", o_hold_req, 1);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0050_0093;
    step();
    check_eq("f_if_valid", o_if_valid, 1);
    check_eq("f_if_rdata", o_if_rdata, 32'h0050_0093);
    check_eq("f_hold_n2", o_hold_req, 0);
    check_eq("f_d_valid", o_d_valid, 0);
    i_if_req = 1'b0; i_mem_ack = 1'b0;
    step();
    check_eq("f_if_valid_once", o_if_valid, 0);

    // store with 3 wait states
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h2000; i_d_wdata = 32'hDEAD_BEEF; i_d_wmask = 4'hF;
    step();
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("s_mem_req%0d", c), o_mem_req, 1);
      check_eq($sformatf("s_mem_addr%0d", c), o_mem_addr, 32'h2000);
      check_eq($sformatf("s_mem_wdata%0d", c), o_mem_wdata, 32'hDEAD_BEEF);
      check_eq($sformatf("s_mem_wmask%0d", c), o_mem_wmask, 4'hF);
      check_eq($sformatf("s_mem_we%0d", c), o_mem_we, 1);
      check_eq($sformatf("s_d_valid%0d", c), o_d_valid, 0);
      i_d_addr = 32'h5555; i_d_wdata = 32'h0; i_d_wmask = 4'h0;
      step();
    end
    check_eq("s_mem_addr_ack", o_mem_addr, 32'h2000);
    i_mem_ack = 1'b1;
    step();
    check_eq("s_d_valid", o_d_valid, 1);
    check_eq("s_if_valid", o_if_valid, 0);
    i_d_req = 1'b0; i_d_we = 1'b0; i_mem_ack = 1'b0;
    step();
    check_eq("s_d_valid_once", o_d_valid, 0);
    check_eq("s_mem_req_idle", o_mem_req, 0);

    // simultaneous requests: D D D IF D D D IF
    i_if_req = 1'b1; i_if_addr = 32'h400;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h800;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      step();
      if (o_mem_req) begin
        check_eq($sformatf("grant%0d", k), o_mem_addr, grant_exp[k]);
        k++;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_0000 + 32'(k);
      end else begin
        i_mem_ack = 1'b0;
      end
    end
    check_eq("grant_count", k, 8);
    step();
    check_eq("arb_last_if_valid", o_if_valid, 1);
    check_eq("arb_last_if_rdata", o_if_rdata, 32'h1111_0008);
    i_if_req = 1'b0; i_d_req = 1'b0; i_mem_ack = 1'b0;
    step();

    // spurious ack while idle
    i_mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check_eq($sformatf("sp_mem_req%0d", c), o_mem_req, 0);
      check_eq($sformatf("sp_if_valid%0d", c), o_if_valid, 0);
      check_eq($sformatf("sp_d_valid%0d", c), o_d_valid, 0);
    end
    i_mem_ack = 1'b0;

    // reset mid-transaction, then a late ack
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h3000; i_d_wdata = 32'h1234_5678; i_d_wmask = 4'h3;
    step();
    check_eq("r_busy_mem_req", o_mem_req, 1);
    i_reset = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
    #1;
    check_eq("r_mem_req", o_mem_req, 0);
    check_eq("r_mem_we", o_mem_we, 0);
    check_eq("r_mem_addr", o_mem_addr, 0);
    check_eq("r_mem_wdata", o_mem_wdata, 0);
    check_eq("r_mem_wmask", o_mem_wmask, 0);
    check_eq("r_if_rdata", o_if_rdata, 0);
    check_eq("r_d_rdata", o_d_rdata, 0);
    check_eq("r_starve", dut.starve_cnt_q, 0);
    step();
    i_reset = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    step();
    check_eq("r_late_d_valid", o_d_valid, 0);
    check_eq("r_late_mem_req", o_mem_req, 0);
    check_eq("r_late_d_rdata", o_d_rdata, 0);
    i_mem_ack = 1'b0;
    i_if_req = 1'b1; i_if_addr = 32'h500;
    step();
    check_eq("r_f_mem_req", o_mem_req, 1);
    check_eq("r_f_mem_addr", o_mem_addr, 32'h500);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0BAD_F00D;
    step();
    check_eq("r_f_if_valid", o_if_valid, 1);
    check_eq("r_f_if_rdata", o_if_rdata, 32'h0BAD_F00D);
    i_if_req = 1'b0; i_mem_ack = 1'b0;
    step();

    // request withdrawn after grant
    i_if_req = 1'b1; i_if_addr = 32'h600;
    step();
    i_if_req = 1'b0;
    #1;
    check_eq("w_hold", o_hold_req, 0);
    check_eq("w_mem_req", o_mem_req, 1);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
    step();
    check_eq("w_if_valid", o_if_valid, 1);
    check_eq("w_if_rdata", o_if_rdata, 32'hCAFE_F00D);
    check_eq("w_hold_valid", o_hold_req, 0);
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    step();
    check_eq("w_if_valid_once", o_if_valid, 0);
    check_eq("w_if_rdata_hold", o_if_rdata, 32'hCAFE_F00D);
    check_eq("w_mem_req_idle", o_mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
